booth_mult_arbiter: RTL

BOOTH_MULT_ARBITER -- requirements
Module: booth_mult_arbiter

---
 rtl/booth_mult_arbiter_if.sv | 31 +++
 rtl/booth_mult_arbiter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/booth_mult_arbiter_if.sv
// Requester and multiplier bus for the shared Booth multiplier arbiter.
// slave = arbiter side, master = requesters plus multiplier side.
interface booth_mult_arbiter_if #(
   parameter int WIDTH = 8
);
   logic [3:0]         req;
   logic [4*WIDTH-1:0] op_a;
   logic [4*WIDTH-1:0] op_b;
   logic [3:0]         ack;
   logic [2*WIDTH-1:0] result;
   logic               err;
   logic               m_valid;
   logic [WIDTH-1:0]   m_a;
   logic [WIDTH-1:0]   m_b;
   logic               m_done;
   logic [2*WIDTH-1:0] m_product;

   modport slave (
      input  req, op_a, op_b,
      input  m_done, m_product,
      output ack, result, err,
      output m_valid, m_a, m_b
   );

   modport master (
      output req, op_a, op_b,
      output m_done, m_product,
      input  ack, result, err,
      input  m_valid, m_a, m_b
   );
endinterface

// File: rtl/booth_mult_arbiter.sv
// Round-robin arbiter sharing one Booth multiplier among four requesters.
// Define ARB_TIMEOUT_EN to bound the WAIT state to TIMEOUT cycles.
module booth_mult_arbiter #(
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 64
) (
   input logic                 clk,
   input logic                 rst,
   booth_mult_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE, ISSUE, WAIT, RESP
   } state_t;

   state_t             state, state_n;
   logic [1:0]         ptr, ptr_n;
   logic [1:0]         sel, sel_n;
   logic [1:0]         pick;
   logic               found;
   logic [WIDTH-1:0]   a_q, a_n;
   logic [WIDTH-1:0]   b_q, b_n;
   logic [2*WIDTH-1:0] res_q, res_n;

`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt, cnt_n;
   logic          err_q, err_n;
`endif

   // first requesting index after ptr, wrapping modulo 4
   always_comb begin
      found = 1'b0;
      pick  = ptr;
      for (int k = 1; k <= 4; k++) begin
         if (!found && bus.req[ptr + 2'(k)]) begin
            found = 1'b1;
            pick  = ptr + 2'(k);
         end
      end
   end

   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      sel_n   = sel;
      a_n     = a_q;
      b_n     = b_q;
      res_n   = res_q;
`ifdef ARB_TIMEOUT_EN
      cnt_n   = cnt;
      err_n   = err_q;
`endif
      unique case (state)
         IDLE: begin
            if (found) begin
               sel_n   = pick;
               a_n     = bus.op_a[int'(pick)*WIDTH +: WIDTH];
               b_n     = bus.op_b[int'(pick)*WIDTH +: WIDTH];
               state_n = ISSUE;
`ifdef ARB_TIMEOUT_EN
               err_n   = 1'b0;
`endif
            end
         end
         ISSUE: begin
            state_n = WAIT;
`ifdef ARB_TIMEOUT_EN
            cnt_n   = '0;
`endif
         end
         WAIT: begin
            if (bus.m_done) begin
               res_n   = bus.m_product;
               state_n = RESP;
            end
`ifdef ARB_TIMEOUT_EN
            else if (cnt == CW'(TIMEOUT - 1)) begin
               res_n   = '0;
               err_n   = 1'b1;
               state_n = RESP;
            end else begin
               cnt_n = cnt + 1'b1;
            end
`endif
         end
         RESP: begin
            ptr_n   = sel;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         ptr   <= 2'd3;
         sel   <= '0;
         a_q   <= '0;
         b_q   <= '0;
         res_q <= '0;
`ifdef ARB_TIMEOUT_EN
         cnt   <= '0;
         err_q <= 1'b0;
`endif
      end else begin
         state <= state_n;
         ptr   <= ptr_n;
         sel   <= sel_n;
         a_q   <= a_n;
         b_q   <= b_n;
         res_q <= res_n;
`ifdef ARB_TIMEOUT_EN
         cnt   <= cnt_n;
         err_q <= err_n;
`endif
      end
   end

   assign bus.m_valid = (state == ISSUE);
   assign bus.m_a     = a_q;
   assign bus.m_b     = b_q;
   assign bus.result  = res_q;
   assign bus.ack     = (state == RESP) ? (4'b0001 << sel) : 4'b0000;
`ifdef ARB_TIMEOUT_EN
   assign bus.err     = (state == RESP) && err_q;
`else
   assign bus.err     = 1'b0;
`endif
endmodule
